tweet_ram_arbiter: RTL

TWEET_RAM_ARBITER -- requirements
Module: tweet_ram_arbiter

---
 rtl/tweet_pkg.sv | 18 +
 rtl/tweet_ram_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/tweet_pkg.sv
`timescale 1ns/1ps
// Shared geometry and FSM encoding for the tweet RAM and its store/playback controllers.
package tweet_pkg;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int LIMIT = 160;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;

    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

endpackage

// File: rtl/tweet_ram_arbiter.sv
`timescale 1ns/1ps
// Single-port RAM arbiter: clear sweep, bounded store-path writes and playback reads,
// one RAM access per cycle with round-robin between writer and reader.
module tweet_ram_arbiter #(
    parameter int AW             = tweet_pkg::AW,
    parameter int DW             = tweet_pkg::DW,
    parameter int LIMIT          = tweet_pkg::LIMIT,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          wr_err,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    import tweet_pkg::*;

    localparam logic [AW:0]   LIMIT_W = (AW+1)'(LIMIT);
    localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          auto_q, auto_d;
    logic          done_q, done_d;
    logic          wr_in_range;

    assign wr_in_range = ({1'b0, wr_addr} < LIMIT_W);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        auto_d  = auto_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_req || auto_q) begin
                    state_d = ST_CLEAR;
                    auto_d  = 1'b0;
                    cnt_d   = '0;
                end else if (wr_req && (!rd_req || last_q == GRANT_RD)) begin
                    state_d = ST_WRITE;
                    last_d  = GRANT_WR;
                end else if (rd_req) begin
                    state_d = ST_READ;
                    last_d  = GRANT_RD;
                end
            end
            ST_CLEAR: begin
                // counter wraps to zero on the final address, ready for the next sweep
                cnt_d = cnt_q + CNT_ONE;
                if (&cnt_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ:  state_d = ST_RDATA;
            ST_RDATA: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        clr_busy = 1'b0;
        wr_ack   = 1'b0;
        wr_err   = 1'b0;
        rd_valid = 1'b0;
        rd_data  = '0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state_q)
            ST_CLEAR: begin
                clr_busy = 1'b1;
                ram_we   = 1'b1;
                ram_addr = cnt_q;
            end
            ST_WRITE: begin
                wr_ack = 1'b1;
                if (wr_in_range) begin
                    ram_we   = 1'b1;
                    ram_addr = wr_addr;
                    ram_din  = wr_data;
                end else begin
                    wr_err = 1'b1;
                end
            end
            ST_READ: ram_addr = rd_addr;
            ST_RDATA: begin
                rd_valid = 1'b1;
                rd_data  = ram_dout;
            end
            default: ;
        endcase
    end

    assign clr_done = done_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= GRANT_RD;
            auto_q  <= (CLEAR_ON_RESET != 0);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            auto_q  <= auto_d;
            done_q  <= done_d;
        end
    end

endmodule
